// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone master bridge.
package wb_pkg;

    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_SELW = 4;
    // Storage width for the request tag. Tags wider than this are truncated.
    localparam int unsigned WB_TAGW = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        STB,
        RWAIT
    } wb_state_e;

    typedef struct packed {
        logic [WB_AW-1:0]   addr;
        logic [WB_DW-1:0]   wdata;
        logic [WB_SELW-1:0] be;
        logic               we;
        logic [WB_TAGW-1:0] tag;
    } wb_req_t;

endpackage

// File: rtl/wb_master_bridge.sv
// Core request/grant port to Wishbone classic single-access master.
// One transaction in flight; bounded retry on rty and a cycle timeout.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int unsigned TAGSIZE   = 1,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [WB_AW-1:0]    addr_i,
    input  logic [WB_DW-1:0]    wdata_i,
    input  logic [WB_SELW-1:0]  be_i,
    input  logic [TAGSIZE-1:0]  tag_i,
    output logic                gnt_o,
    output logic                rvalid_o,
    output logic [WB_DW-1:0]    rdata_o,
    output logic                err_o,
    output logic [WB_DW-1:0]    wb_dat_o,
    output logic [WB_AW-1:0]    wb_adr_o,
    output logic [WB_SELW-1:0]  wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic [TAGSIZE-1:0]  wb_tga_o,
    output logic [TAGSIZE-1:0]  wb_tgd_o,
    output logic [TAGSIZE-1:0]  wb_tgc_o,
    input  logic                wb_gnt_i,
    input  logic [WB_DW-1:0]    wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic                wb_rty_i
);

    localparam int unsigned RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    wb_state_e           state_q, state_d;
    wb_req_t             req_q, req_d;
    logic [RCW-1:0]      rty_cnt_q, rty_cnt_d;
    logic [7:0]          tmo_cnt_q, tmo_cnt_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [WB_DW-1:0]    rdata_q, rdata_d;

    logic                accept;
    logic                tmo_hit;
    logic                retry_left;
    logic                done_ok;
    logic                done_err;
    logic                do_retry;

    assign accept     = (state_q == IDLE) && req_i;
    // >= rather than == so a retry issued on the last allowed cycle still
    // times out in the following RWAIT instead of wrapping the counter.
    assign tmo_hit    = (tmo_cnt_q >= 8'(TIMEOUT - 1));
    assign retry_left = (rty_cnt_q < RCW'(MAX_RETRY));

    // Decode how the current cycle ends: ack > err > rty, then grant loss / timeout
    always_comb begin
        done_ok  = 1'b0;
        done_err = 1'b0;
        do_retry = 1'b0;
        case (state_q)
            STB: begin
                if (wb_ack_i) begin
                    done_ok = 1'b1;
                end else if (wb_err_i) begin
                    done_err = 1'b1;
                end else if (wb_rty_i) begin
                    if (retry_left) do_retry = 1'b1;
                    else            done_err = 1'b1;
                end else if (!wb_gnt_i || tmo_hit) begin
                    done_err = 1'b1;
                end
            end
            ARB, RWAIT: done_err = tmo_hit;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_i) state_d = ARB;
            ARB: begin
                if (done_err)      state_d = IDLE;
                else if (wb_gnt_i) state_d = STB;
            end
            STB: begin
                if (done_ok || done_err) state_d = IDLE;
                else if (do_retry)       state_d = RWAIT;
            end
            RWAIT: state_d = done_err ? IDLE : STB;
            default: state_d = IDLE;
        endcase
    end

    // Bus and core-side outputs decoded from state
    always_comb begin
        gnt_o    = (state_q == IDLE) && req_i && rstn_i;
        wb_cyc_o = (state_q != IDLE);
        wb_stb_o = (state_q == STB);
        wb_adr_o = wb_cyc_o ? req_q.addr  : '0;
        wb_dat_o = wb_cyc_o ? req_q.wdata : '0;
        wb_sel_o = wb_cyc_o ? req_q.be    : '0;
        wb_we_o  = wb_cyc_o && req_q.we;
        wb_tga_o = wb_cyc_o ? TAGSIZE'(req_q.tag) : '0;
        wb_tgd_o = wb_cyc_o ? TAGSIZE'(req_q.tag) : '0;
        wb_tgc_o = wb_cyc_o ? TAGSIZE'(req_q.tag) : '0;
        rvalid_o = rvalid_q;
        err_o    = err_q;
        rdata_o  = rdata_q;
    end

    // Request capture, counters and next-cycle response
    always_comb begin
        req_d     = req_q;
        rty_cnt_d = rty_cnt_q;
        tmo_cnt_d = (state_q == IDLE) ? 8'd0 : tmo_cnt_q + 8'd1;
        if (accept) begin
            req_d.addr  = addr_i;
            req_d.wdata = wdata_i;
            req_d.be    = be_i;
            req_d.we    = we_i;
            req_d.tag   = WB_TAGW'(tag_i);
            rty_cnt_d   = '0;
        end else if (do_retry) begin
            rty_cnt_d = rty_cnt_q + RCW'(1);
        end
        rvalid_d = done_ok || done_err;
        err_d    = done_err;
        rdata_d  = (done_ok && !req_q.we) ? wb_dat_i : '0;
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            req_q     <= '0;
            rty_cnt_q <= '0;
            tmo_cnt_q <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            req_q     <= req_d;
            rty_cnt_q <= rty_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge. Each transaction is expanded by a
// timeline model into per-cycle stimulus and expected outputs, then replayed.
module tb_wb_master_bridge;

    localparam int unsigned TAGSIZE   = 2;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned TIMEOUT   = 255;
    localparam int          NC        = 1024;

    typedef enum int { K_ACK, K_ERR, K_ALL, K_GDROP } kind_e;

    logic                clk = 1'b0;
    logic                rstn_i = 1'b1;
    logic                req_i = 1'b0, we_i = 1'b0;
    logic [31:0]         addr_i = '0, wdata_i = '0;
    logic [3:0]          be_i = '0;
    logic [TAGSIZE-1:0]  tag_i = '0;
    logic                gnt_o, rvalid_o, err_o;
    logic [31:0]         rdata_o, wb_dat_o, wb_adr_o;
    logic [3:0]          wb_sel_o;
    logic                wb_we_o, wb_cyc_o, wb_stb_o;
    logic [TAGSIZE-1:0]  wb_tga_o, wb_tgd_o, wb_tgc_o;
    logic                wb_gnt_i = 1'b0, wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
    logic [31:0]         wb_dat_i = '0;

    always #5 clk = ~clk;

    wb_master_bridge #(
        .TAGSIZE   (TAGSIZE),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i    (clk),
        .rstn_i   (rstn_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .be_i     (be_i),
        .tag_i    (tag_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .wb_dat_o (wb_dat_o),
        .wb_adr_o (wb_adr_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_tga_o (wb_tga_o),
        .wb_tgd_o (wb_tgd_o),
        .wb_tgc_o (wb_tgc_o),
        .wb_gnt_i (wb_gnt_i),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i)
    );

    // Per-cycle stimulus
    logic               in_rst [NC];
    logic               in_req [NC];
    logic               in_we  [NC];
    logic [31:0]        in_addr[NC];
    logic [31:0]        in_wd  [NC];
    logic [3:0]         in_be  [NC];
    logic [TAGSIZE-1:0] in_tag [NC];
    logic               in_gnt [NC];
    logic               in_ack [NC];
    logic               in_err [NC];
    logic               in_rty [NC];
    logic [31:0]        in_dat [NC];
    // Per-cycle expectations
    logic               chk_zero [NC];
    logic               exp_gnt  [NC];
    logic               exp_cyc  [NC];
    logic               exp_stb  [NC];
    logic               exp_rv   [NC];
    logic               exp_err  [NC];
    logic [31:0]        exp_rd   [NC];
    logic [31:0]        exp_adr  [NC];
    logic [31:0]        exp_dat  [NC];
    logic [3:0]         exp_sel  [NC];
    logic               exp_we   [NC];
    logic [TAGSIZE-1:0] exp_tag  [NC];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int          cur = 0;
    logic        play = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: actual 0x%0h required 0x%0h", name, cur, act, exp);
        end
    endtask

    task automatic clear_cycle(input int c);
        in_rst[c] = 0; in_req[c] = 0; in_we[c] = 0; in_addr[c] = '0; in_wd[c] = '0;
        in_be[c] = '0; in_tag[c] = '0; in_gnt[c] = 0; in_ack[c] = 0; in_err[c] = 0;
        in_rty[c] = 0; in_dat[c] = '0;
        chk_zero[c] = 0; exp_gnt[c] = 0; exp_cyc[c] = 0; exp_stb[c] = 0; exp_rv[c] = 0;
        exp_err[c] = 0; exp_rd[c] = '0; exp_adr[c] = '0; exp_dat[c] = '0;
        exp_sel[c] = '0; exp_we[c] = 0; exp_tag[c] = '0;
    endtask

    // Timeline model: offset 0 = accept, ARB from 1, first strobe the cycle
    // after grant, one idle cycle between retry strobes, response one cycle
    // after the terminating cycle. ws = wait cycles on the final strobe.
    task automatic sched(input int c0, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [TAGSIZE-1:0] tag, input logic [31:0] rd,
                         input int gdly, input int nrty, input int ws,
                         input kind_e kind, output int endo);
        int   first, nret, s_fin, tend, c;
        logic exhaust, tmo, ok;
        first   = 2 + gdly;
        exhaust = (nrty > int'(MAX_RETRY));
        nret    = exhaust ? int'(MAX_RETRY) : nrty;
        s_fin   = first + 2 * nret;
        tend    = exhaust ? s_fin : s_fin + ws;
        tmo     = (tend > int'(TIMEOUT));
        endo    = tmo ? int'(TIMEOUT) : tend;
        ok      = !exhaust && !tmo && (kind == K_ACK || kind == K_ALL);

        in_req[c0] = 1; in_we[c0] = we; in_addr[c0] = addr; in_wd[c0] = wdata;
        in_be[c0] = be; in_tag[c0] = tag; exp_gnt[c0] = 1;
        for (int t = 1; t <= endo; t++) begin
            c = c0 + t;
            // core keeps requesting with different fields; all must be ignored
            in_req[c] = 1; in_we[c] = ~we; in_addr[c] = ~addr; in_wd[c] = ~wdata;
            in_be[c] = ~be; in_tag[c] = ~tag;
            exp_gnt[c] = 0; exp_cyc[c] = 1;
            exp_adr[c] = addr; exp_dat[c] = wdata; exp_sel[c] = be; exp_we[c] = we;
            exp_tag[c] = tag;
            exp_stb[c] = (t >= s_fin) || (t >= first && ((t - first) % 2) == 0);
            in_gnt[c]  = (t >= 1 + gdly);
            in_dat[c]  = ~rd;
            if (t >= first && t < s_fin && ((t - first) % 2) == 0) in_rty[c] = 1;
            if (t == endo && !tmo) begin
                in_dat[c] = rd;
                if (exhaust) in_rty[c] = 1;
                else begin
                    case (kind)
                        K_ACK:   in_ack[c] = 1;
                        K_ERR:   in_err[c] = 1;
                        K_ALL:   begin in_ack[c] = 1; in_err[c] = 1; in_rty[c] = 1; end
                        K_GDROP: in_gnt[c] = 0;
                        default: ;
                    endcase
                end
            end
        end
        c = c0 + endo + 1;
        exp_rv[c]  = 1;
        exp_err[c] = !ok;
        exp_rd[c]  = (ok && !we) ? rd : 32'h0;
    endtask

    // Compare process: checks every replayed cycle mid-cycle
    always @(negedge clk) begin
        if (play) begin
            if (chk_zero[cur]) begin
                chk("rst_gnt_o",    32'(gnt_o),    32'h0);
                chk("rst_rvalid_o", 32'(rvalid_o), 32'h0);
                chk("rst_err_o",    32'(err_o),    32'h0);
                chk("rst_rdata_o",  rdata_o,       32'h0);
                chk("rst_wb_cyc_o", 32'(wb_cyc_o), 32'h0);
                chk("rst_wb_stb_o", 32'(wb_stb_o), 32'h0);
                chk("rst_wb_adr_o", wb_adr_o,      32'h0);
                chk("rst_wb_dat_o", wb_dat_o,      32'h0);
                chk("rst_wb_sel_o", 32'(wb_sel_o), 32'h0);
                chk("rst_wb_we_o",  32'(wb_we_o),  32'h0);
                chk("rst_wb_tags",  32'({wb_tga_o, wb_tgd_o, wb_tgc_o}), 32'h0);
            end else begin
                chk("gnt_o",    32'(gnt_o),    32'(exp_gnt[cur]));
                chk("wb_cyc_o", 32'(wb_cyc_o), 32'(exp_cyc[cur]));
                chk("wb_stb_o", 32'(wb_stb_o), 32'(exp_stb[cur]));
                chk("rvalid_o", 32'(rvalid_o), 32'(exp_rv[cur]));
                if (exp_rv[cur]) begin
                    chk("err_o",   32'(err_o), 32'(exp_err[cur]));
                    chk("rdata_o", rdata_o,    exp_rd[cur]);
                end
                if (exp_cyc[cur]) begin
                    chk("wb_adr_o", wb_adr_o,      exp_adr[cur]);
                    chk("wb_dat_o", wb_dat_o,      exp_dat[cur]);
                    chk("wb_sel_o", 32'(wb_sel_o), 32'(exp_sel[cur]));
                    chk("wb_we_o",  32'(wb_we_o),  32'(exp_we[cur]));
                    chk("wb_tga_o", 32'(wb_tga_o), 32'(exp_tag[cur]));
                    chk("wb_tgd_o", 32'(wb_tgd_o), 32'(exp_tag[cur]));
                    chk("wb_tgc_o", 32'(wb_tgc_o), 32'(exp_tag[cur]));
                end
            end
        end
    end

    initial begin
        int c, e, n, r0, ncyc;
        for (int i = 0; i < NC; i++) clear_cycle(i);

        // power-on reset, with req_i high to show gnt_o is held low
        in_rst[0] = 1; chk_zero[0] = 1; in_req[0] = 1;
        in_rst[1] = 1; chk_zero[1] = 1;
        c = 3;

        // read, immediate grant, zero-wait ack
        sched(c, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 2'b01, 32'hDEAD_BEEF, 0, 0, 0, K_ACK, e);
        chk("model_read_end", 32'(e), 32'd2);
        chk("model_read_rdata", exp_rd[c + 3], 32'hDEAD_BEEF);
        c = c + e + 1;  // back-to-back: next accept in the rvalid cycle

        // write, grant delayed 4 cycles
        sched(c, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'b0011, 2'b10, 32'h1234_5678, 4, 0, 0, K_ACK, e);
        chk("model_write_stb_edge", 32'({exp_stb[c + 5], exp_stb[c + 6]}), 32'h1);
        chk("model_write_rdata", exp_rd[c + e + 1], 32'h0);
        c = c + e + 1;

        // rty twice then ack
        sched(c, 1'b0, 32'h0000_3008, 32'h0, 4'hF, 2'b11, 32'hA5A5_0001, 1, 2, 0, K_ACK, e);
        chk("model_retry2_end", 32'(e), 32'd7);
        c = c + e + 1;

        // rty four times: retries exhausted
        sched(c, 1'b0, 32'h0000_400C, 32'h0, 4'hF, 2'b00, 32'h5555_AAAA, 0, 4, 0, K_ACK, e);
        n = 0;
        for (int t = 0; t <= e; t++) n += int'(exp_stb[c + t]);
        chk("model_exhaust_strobes", 32'(n), 32'd4);
        chk("model_exhaust_err", 32'(exp_err[c + e + 1]), 32'h1);
        c = c + e + 1;

        // granted, slave never answers: timeout
        sched(c, 1'b0, 32'h0000_5000, 32'h0, 4'hF, 2'b01, 32'h0000_0055, 0, 0, 999, K_ACK, e);
        chk("model_timeout_end", 32'(e), 32'd255);
        c = c + e + 1;

        // ack+err+rty exactly on the timeout cycle: ack wins
        sched(c, 1'b0, 32'h0000_6000, 32'h0, 4'hF, 2'b10, 32'h0BAD_F00D, 0, 0, 253, K_ALL, e);
        chk("model_late_ok", 32'(exp_err[c + e + 1]), 32'h0);
        c = c + e + 1;

        // ack+err+rty together, zero wait
        sched(c, 1'b0, 32'h0000_7000, 32'h0, 4'hF, 2'b01, 32'h1357_9BDF, 0, 0, 0, K_ALL, e);
        c = c + e + 1;

        // write answered with err
        sched(c, 1'b1, 32'h0000_8000, 32'h0102_0304, 4'b1100, 2'b11, 32'hFFFF_FFFF, 1, 0, 0, K_ERR, e);
        c = c + e + 1;

        // one retry, then grant lost during strobe
        sched(c, 1'b0, 32'h0000_9000, 32'h0, 4'hF, 2'b00, 32'h2468_ACE0, 2, 1, 0, K_GDROP, e);
        c = c + e + 3;

        // reset asserted while strobing; no response may follow
        r0 = c;
        sched(r0, 1'b0, 32'h0000_A000, 32'h0, 4'hF, 2'b01, 32'h7777_7777, 0, 0, 999, K_ACK, e);
        for (int i = r0 + 4; i <= r0 + int'(TIMEOUT) + 1; i++) clear_cycle(i);
        in_rst[r0 + 4] = 1; chk_zero[r0 + 4] = 1; in_req[r0 + 4] = 1;
        in_rst[r0 + 5] = 1; chk_zero[r0 + 5] = 1;
        c = r0 + 8;

        // first request after reset completes normally
        sched(c, 1'b0, 32'h0000_B000, 32'h0, 4'hF, 2'b10, 32'h600D_CAFE, 0, 0, 0, K_ACK, e);
        c = c + e + 4;
        ncyc = c;

        // replay
        #2 rstn_i = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            cur      = i;
            play     = 1'b1;
            rstn_i   = !in_rst[i];
            req_i    = in_req[i];
            we_i     = in_we[i];
            addr_i   = in_addr[i];
            wdata_i  = in_wd[i];
            be_i     = in_be[i];
            tag_i    = in_tag[i];
            wb_gnt_i = in_gnt[i];
            wb_ack_i = in_ack[i];
            wb_err_i = in_err[i];
            wb_rty_i = in_rty[i];
            wb_dat_i = in_dat[i];
        end
        @(posedge clk);
        #1 play = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
